// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Arbitrates two register-file write requesters (A and B) onto a single
// write port. After reset, and on request, every register is swept to zero
// before normal arbitration resumes. In RUN, simultaneous requests are
// resolved round-robin.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   reset_n    : synchronous active-low reset
//   init_req   : request to re-zero all registers (ignored during INIT)
//   a_valid    : requester A write valid
//   a_addr     : requester A destination register
//   a_data     : requester A write data
//   a_ready    : requester A accepted this cycle (combinational)
//   b_*        : requester B, mirrors A
//   we         : registered register-file write enable
//   wr_addr    : registered register-file write address
//   wr_data    : registered register-file write data
//   init_done  : registered, high while in RUN
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_req,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]            state;
  logic                  ptr;
  logic [ADDR_WIDTH-1:0] init_cnt;

  logic grant_ok;

  // Grants are only possible in RUN with no pending re-init. reset_n is
  // folded in so the readies are low for the whole reset cycle, which also
  // discards any acceptance coinciding with a reset edge.
  // NOTE: every output of this block is assigned unconditionally first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    grant_ok = reset_n && (state == ST_RUN) && !init_req;
    if (grant_ok) begin
      if (a_valid && b_valid) begin
        a_ready = (ptr == PTR_A);
        b_ready = (ptr == PTR_B);
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      ptr       <= PTR_A;
      we        <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      // Zero sweep: one register per cycle; init_req has no effect here.
      we        <= 1'b1;
      wr_addr   <= init_cnt;
      wr_data   <= '0;
      init_cnt  <= init_cnt + 1'b1;
      init_done <= 1'b0;
      if (init_cnt == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end else if (init_req) begin
      // Re-init: drop back to INIT; round-robin pointer is preserved and the
      // last write address/data are left as they were.
      state     <= ST_INIT;
      init_cnt  <= '0;
      we        <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (a_ready) begin
        we      <= 1'b1;
        wr_addr <= a_addr;
        wr_data <= a_data;
        ptr     <= PTR_B;
      end else if (b_ready) begin
        we      <= 1'b1;
        wr_addr <= b_addr;
        wr_data <= b_data;
        ptr     <= PTR_A;
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Drives directed scenarios followed by randomized traffic into
// reg_write_arbiter and compares readies and register-file write outputs
// against a behavioural model, plus an acceptance-to-write scoreboard.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NREGS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_req;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          init_done;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_req  (init_req),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_done (init_done)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: sweeping flag with an integer sweep index, and a
  // "B has priority next" flag for the round-robin.
  bit          m_sweeping;
  int          m_sweep_idx;
  bit          m_b_first;
  bit          m_we;
  int          m_addr;
  logic [DW-1:0] m_data;
  bit          m_done;

  // Scoreboard for accepted requests: the write must appear on the next edge.
  bit            sb_pending;
  logic [AW-1:0] sb_addr;
  logic [DW-1:0] sb_data;

  task automatic step(input bit rn, input bit ir,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bit exp_a, exp_b, can_grant;
    reset_n  = rn;
    init_req = ir;
    a_valid  = av; a_addr = aa; a_data = ad;
    b_valid  = bv; b_addr = ba; b_data = bd;

    @(negedge clk);
    can_grant = rn && !m_sweeping && !ir;
    exp_a = can_grant && av && (!bv || !m_b_first);
    exp_b = can_grant && bv && (!av || m_b_first);
    check("a_ready", 64'(a_ready), 64'(exp_a));
    check("b_ready", 64'(b_ready), 64'(exp_b));

    sb_pending = 1'b0;
    if (a_valid && a_ready) begin
      sb_pending = 1'b1; sb_addr = a_addr; sb_data = a_data;
    end else if (b_valid && b_ready) begin
      sb_pending = 1'b1; sb_addr = b_addr; sb_data = b_data;
    end

    @(posedge clk);
    if (!rn) begin
      m_sweeping = 1; m_sweep_idx = 0; m_b_first = 0;
      m_we = 0; m_addr = 0; m_data = '0; m_done = 0;
    end else if (m_sweeping) begin
      m_we = 1; m_addr = m_sweep_idx; m_data = '0; m_done = 0;
      if (m_sweep_idx == NREGS - 1) begin
        m_sweeping  = 0;
        m_sweep_idx = 0;
      end else begin
        m_sweep_idx++;
      end
    end else if (ir) begin
      m_sweeping = 1; m_sweep_idx = 0; m_we = 0; m_done = 0;
    end else begin
      m_done = 1;
      m_we   = exp_a || exp_b;
      if (exp_a) begin
        m_addr = int'(aa); m_data = ad; m_b_first = 1;
      end else if (exp_b) begin
        m_addr = int'(ba); m_data = bd; m_b_first = 0;
      end
    end

    #1;
    check("we",        64'(we),        64'(m_we));
    check("wr_addr",   64'(wr_addr),   64'(m_addr));
    check("wr_data",   64'(wr_data),   64'(m_data));
    check("init_done", 64'(init_done), 64'(m_done));
    if (sb_pending && rn) begin
      check("sb_we",   64'(we),                  64'(1));
      check("sb_wr",   64'({wr_addr, wr_data}),  64'({sb_addr, sb_data}));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  logic [DW-1:0] seq [4];

  initial begin
    m_sweeping = 1; m_sweep_idx = 0; m_b_first = 0;
    m_we = 0; m_addr = 0; m_data = '0; m_done = 0;

    // Reset held for two edges.
    step(0, 0, 1, 4'h1, 32'h1, 1, 4'h2, 32'h2);
    step(0, 1, 0, '0, '0, 0, '0, '0);
    check("rst_we", 64'(we), 64'(0));

    // Zero sweep of 16 registers, then first RUN edge shows init_done.
    for (int i = 0; i < NREGS; i++) begin
      step(1, 1, 0, '0, '0, 0, '0, '0);
      check("sweep_addr", 64'(wr_addr), 64'(i));
    end
    idle(1);
    check("sweep_done", 64'({we, init_done}), 64'(2'b01));

    // Both valid for 4 cycles starting with pointer on A: A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 4'h1, 32'h11, 1, 4'h2, 32'h22);
      seq[i] = wr_data;
      check("rr_we", 64'(we), 64'(1));
    end
    check("rr_order", 64'({seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}),
          64'(32'h11221122));

    // A alone to register 3.
    step(1, 0, 1, 4'h3, 32'h23, 0, '0, '0);
    check("a_only", 64'({we, wr_addr, wr_data}), 64'({1'b1, 4'h3, 32'h23}));

    // Same address from both: pointer is now B, so B then A (last = A's 7).
    step(1, 0, 1, 4'h5, 32'h7, 1, 4'h5, 32'h9);
    step(1, 0, 1, 4'h5, 32'h7, 0, '0, '0);
    check("same_addr_last", 64'({wr_addr, wr_data}), 64'({4'h5, 32'h7}));

    // Re-init pulse with A waiting, A stays valid across the sweep.
    step(1, 1, 1, 4'h6, 32'h66, 0, '0, '0);
    for (int i = 0; i < NREGS; i++) step(1, 0, 1, 4'h6, 32'h66, 0, '0, '0);
    step(1, 0, 1, 4'h6, 32'h66, 0, '0, '0);
    check("reinit_grant", 64'({we, init_done, wr_addr, wr_data}),
          64'({2'b11, 4'h6, 32'h66}));

    // Reset mid-sweep with counter at 7, sweep restarts at 0.
    step(0, 0, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, '0, '0, 0, '0, '0);
    step(0, 0, 1, 4'h9, 32'h99, 0, '0, '0);
    check("midsweep_rst_we", 64'(we), 64'(0));
    step(1, 0, 0, '0, '0, 0, '0, '0);
    check("restart_addr", 64'({we, wr_addr}), 64'({1'b1, 4'h0}));
    idle(NREGS);

    // Randomized traffic with occasional re-init and reset.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 6), AW'($urandom), $urandom,
           ($urandom_range(0, 9) < 6), AW'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
